motor_arm_sequencer: RTL and testbench
======================================

# motor_arm_sequencer

Sequences motor throttle commands between the SPI receive path and the four ESC pulse generators. It latches 32-bit command frames and enforces an arming sequence before any nonzero throttle reaches the ESCs. It slew-limits each motor at ESC frame boundaries and drives a failsafe ramp-down when commands stop arriving. It sits on the 40 MHz clock domain, between the synchronized SPI `done`/data and the per-motor ESC registers.

## Interface
- `ARM_FRAMES`, 100: ESC frames of zero throttle required in ARMING (100 × 20 ms = 2 s).
- `TIMEOUT_FRAMES`, 10: frames without a `cmd_valid` before ARMED enters FAILSAFE.
- `MAX_STEP`, 4: maximum per-motor change per frame, in counts (range 1..255).
- `clk` in 1: 40 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: one-cycle strobe; `cmd_data` is valid (already synchronized to `clk`).
- `cmd_data` in 32: targets; [31:24] front, [23:16] left, [15:8] right, [7:0] back.
- `frame_tick` in 1: one-cycle strobe at the start of each 20 ms ESC period.
- `arm_req` in 1: level; high requests arming, low requests disarm.
- `kill` in 1: level; immediate disarm, highest priority.
- `motor_out` out 32: registered throttle to the ESC registers, same byte order as `cmd_data`.
- `state` out 2: 00 DISARMED, 01 ARMING, 10 ARMED, 11 FAILSAFE.
- `armed` out 1: high only in ARMED.
- `cmd_ack` out 1: one-cycle pulse, the cycle after each accepted `cmd_valid`.

## Operation
- Target register (4×8) loads `cmd_data` on every `cmd_valid`, in every state.
- `cmd_ack` pulses for every `cmd_valid`, including commands that are ignored for output purposes.
- **DISARMED**
  - `motor_out` = 0.
  - Transitions to ARMING when `arm_req`=1, `kill`=0, and all targets are 0.
- **ARMING**
  - `motor_out` = 0; the frame counter increments on each `frame_tick`.
  - Any of these returns to DISARMED and clears the counter: `arm_req`=0, `kill`=1, or a target becoming nonzero.
  - When the counter reaches `ARM_FRAMES`, go to ARMED, clear the counter, and clear the watchdog.
- **ARMED**
  - On each `frame_tick`, each motor slews toward its target. If out<tgt: out += min(MAX_STEP, tgt−out). If out>tgt: out −= min(MAX_STEP, out−tgt).
  - Slew math is 9-bit; the result never overshoots the target, never wraps, and saturates within 0..255.
  - The watchdog clears on `cmd_valid` and increments on `frame_tick`. When it reaches `TIMEOUT_FRAMES`, go to FAILSAFE.
  - `arm_req`=0 or `kill`=1: go to DISARMED and force `motor_out`=0 in the same update.
- **FAILSAFE**
  - On each `frame_tick`, each motor decreases by min(MAX_STEP, out); targets are ignored.
  - `cmd_valid` does not recover the block.
  - `arm_req`=0 or `kill`=1: go to DISARMED with `motor_out`=0.
  - While `arm_req` stays high, outputs remain at 0 after the ramp completes.
- Priority within one cycle: `kill` > `arm_req`=0 > watchdog expiry > slew/arming count.

## Timing
- Reset values:
  - `motor_out`=0, `state`=00, `armed`=0, `cmd_ack`=0.
  - Targets, arming counter and watchdog = 0.
- Reset mid-operation returns the block to DISARMED asynchronously, with outputs 0 and no ramp.
- `motor_out` updates on the edge after `frame_tick` is sampled (1-cycle latency); it holds between ticks.
- State transitions are registered: `state`/`armed` change on the edge after the causing input is sampled.
- `cmd_valid` and `frame_tick` in the same cycle:
  - The slew uses the old target; the new target applies from the next tick.
  - The watchdog clears; clear wins over increment and expiry.
- The arming counter and watchdog saturate at their parameter value; they never wrap.
- `kill` or disarm takes effect one cycle after sampling, regardless of `frame_tick`.
- Back-to-back `cmd_valid` on consecutive cycles: both accepted, last one wins, two `cmd_ack` pulses.

## Test plan
- **Reset then arm:** reset low → all outputs 0, `state`=00. Release, send cmd 0x00000000, hold `arm_req`=1, issue 100 ticks → `state`=10, `armed`=1 one cycle after the 100th tick.
- **Arm rejected:** target 0x10000000 with `arm_req`=1 → stays DISARMED. Mid-ARMING cmd 0x00000001 → DISARMED, counter cleared.
- **Slew:** ARMED, cmd 0x0A_FF_00_03 with `MAX_STEP`=4 from 0 → after ticks 1/2/3, front = 4/8/10 and back = 3/3/3. Then cmd 0 → front = 6/2/0, no underflow.
- **Watchdog:** ARMED with outputs 0x20202020, no cmd for 10 ticks → FAILSAFE after the 10th tick, then each motor falls by 4 per tick to 0. A `cmd_valid` on the same cycle as the 10th tick → remains ARMED.
- **Kill:** `kill`=1 while ARMED with outputs 0x80808080 → DISARMED and `motor_out`=0 next cycle. `arm_req` still high with zero target → re-enters ARMING only after `kill`=0.
- **Ack and collision:** `cmd_valid` on consecutive cycles plus a `frame_tick` coincident with the first → two `cmd_ack` pulses, the slew uses the pre-collision target, and the final target equals the second `cmd_data`.

Source files
------------

// File: rtl/motor_arm_sequencer.sv
// Motor throttle sequencer: latches command frames, gates throttle behind a timed
// arming sequence, slew-limits each motor per ESC frame and ramps down on command loss.
module motor_arm_sequencer #(
    parameter int ARM_FRAMES     = 100,
    parameter int TIMEOUT_FRAMES = 10,
    parameter int MAX_STEP       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    input  logic        frame_tick,
    input  logic        arm_req,
    input  logic        kill,
    output logic [31:0] motor_out,
    output logic [1:0]  state,
    output logic        armed,
    output logic        cmd_ack
);

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMING   = 2'b01,
        ARMED    = 2'b10,
        FAILSAFE = 2'b11
    } state_t;

    localparam int ARM_W = $clog2(ARM_FRAMES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_FRAMES);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_FRAMES);
    localparam logic [7:0]       STEP     = 8'(MAX_STEP);

    state_t           state_q, state_d;
    logic [31:0]      tgt_q;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [31:0]      motor_d, slew_v, ramp_v;
    logic             disarm;

    function automatic logic [7:0] min_step(input logic [7:0] gap);
        return (gap < STEP) ? gap : STEP;
    endfunction

    // The step is bounded by the remaining gap, so the result can neither overshoot nor wrap.
    function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] res;
        res = cur;
        if (tgt > cur)
            res = cur + min_step(tgt - cur);
        else if (cur > tgt)
            res = cur - min_step(cur - tgt);
        return res;
    endfunction

    always_comb begin
        slew_v = '0;
        ramp_v = '0;
        for (int m = 0; m < 4; m++) begin
            slew_v[m*8 +: 8] = slew_toward(motor_out[m*8 +: 8], tgt_q[m*8 +: 8]);
            ramp_v[m*8 +: 8] = motor_out[m*8 +: 8] - min_step(motor_out[m*8 +: 8]);
        end
    end

    assign disarm = kill | ~arm_req;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        wd_d      = wd_q;
        motor_d   = motor_out;
        unique case (state_q)
            DISARMED: begin
                motor_d   = '0;
                arm_cnt_d = '0;
                wd_d      = '0;
                if (!disarm && tgt_q == '0)
                    state_d = ARMING;
            end
            ARMING: begin
                motor_d = '0;
                wd_d    = '0;
                if (disarm || tgt_q != '0) begin
                    state_d   = DISARMED;
                    arm_cnt_d = '0;
                end else if (frame_tick) begin
                    if (arm_cnt_q >= ARM_DONE - 1'b1) begin
                        state_d   = ARMED;
                        arm_cnt_d = '0;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end
            end
            ARMED: begin
                if (disarm) begin
                    state_d = DISARMED;
                    motor_d = '0;
                    wd_d    = '0;
                end else if (cmd_valid) begin
                    wd_d = '0;
                    if (frame_tick)
                        motor_d = slew_v;
                end else if (frame_tick) begin
                    // Expiry outranks the slew: the expiring tick leaves the outputs where they are.
                    if (wd_q >= WD_LIMIT - 1'b1) begin
                        wd_d    = WD_LIMIT;
                        state_d = FAILSAFE;
                    end else begin
                        wd_d    = wd_q + 1'b1;
                        motor_d = slew_v;
                    end
                end
            end
            FAILSAFE: begin
                if (disarm) begin
                    state_d = DISARMED;
                    motor_d = '0;
                    wd_d    = '0;
                end else if (frame_tick) begin
                    motor_d = ramp_v;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= DISARMED;
            tgt_q     <= '0;
            arm_cnt_q <= '0;
            wd_q      <= '0;
            motor_out <= '0;
            cmd_ack   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            wd_q      <= wd_d;
            motor_out <= motor_d;
            cmd_ack   <= cmd_valid;
            if (cmd_valid)
                tgt_q <= cmd_data;
        end
    end

    assign state = state_q;
    assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_motor_arm_sequencer.sv
// Self-checking bench for motor_arm_sequencer: vector table, directed multi-cycle
// sequences and randomized episodes compared against a frame-level reference model.
module tb_motor_arm_sequencer;

    localparam int ARM_FRAMES     = 100;
    localparam int TIMEOUT_FRAMES = 10;
    localparam int MAX_STEP       = 4;
    localparam int S_DIS = 0, S_ARMING = 1, S_ARMED = 2, S_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        frame_tick = 1'b0;
    logic        arm_req = 1'b0;
    logic        kill = 1'b0;
    logic [31:0] motor_out;
    logic [1:0]  state;
    logic        armed;
    logic        cmd_ack;

    int n_checks = 0;
    int n_fail   = 0;

    motor_arm_sequencer #(
        .ARM_FRAMES    (ARM_FRAMES),
        .TIMEOUT_FRAMES(TIMEOUT_FRAMES),
        .MAX_STEP      (MAX_STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .frame_tick(frame_tick),
        .arm_req   (arm_req),
        .kill      (kill),
        .motor_out (motor_out),
        .state     (state),
        .armed     (armed),
        .cmd_ack   (cmd_ack)
    );

    always #10 clk = ~clk;

    // Reference model: motors as plain integers, index 0 = front.
    int m_state;
    int m_out[4];
    int m_tgt[4];
    int m_cnt;
    int m_wd;
    bit m_ack;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_state = S_DIS;
        m_cnt   = 0;
        m_wd    = 0;
        m_ack   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 0;
            m_tgt[i] = 0;
        end
    endfunction

    function automatic void model_slew();
        for (int i = 0; i < 4; i++) begin
            if (m_out[i] < m_tgt[i])
                m_out[i] = m_out[i] + imin(MAX_STEP, m_tgt[i] - m_out[i]);
            else if (m_out[i] > m_tgt[i])
                m_out[i] = m_out[i] - imin(MAX_STEP, m_out[i] - m_tgt[i]);
        end
    endfunction

    function automatic void model_update(input logic v, input logic [31:0] d,
                                         input logic t, input logic a, input logic k);
        int  tsum;
        bit  stop;
        tsum = m_tgt[0] + m_tgt[1] + m_tgt[2] + m_tgt[3];
        stop = k || !a;
        m_ack = v;
        case (m_state)
            S_DIS: begin
                m_cnt = 0;
                if (!stop && tsum == 0)
                    m_state = S_ARMING;
            end
            S_ARMING: begin
                if (stop || tsum != 0) begin
                    m_state = S_DIS;
                    m_cnt   = 0;
                end else if (t) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt >= ARM_FRAMES) begin
                        m_state = S_ARMED;
                        m_cnt   = 0;
                        m_wd    = 0;
                    end
                end
            end
            S_ARMED: begin
                if (stop) begin
                    m_state = S_DIS;
                    for (int i = 0; i < 4; i++) m_out[i] = 0;
                end else if (v) begin
                    m_wd = 0;
                    if (t) model_slew();
                end else if (t) begin
                    m_wd = m_wd + 1;
                    if (m_wd >= TIMEOUT_FRAMES)
                        m_state = S_FAIL;
                    else
                        model_slew();
                end
            end
            default: begin
                if (stop) begin
                    m_state = S_DIS;
                    for (int i = 0; i < 4; i++) m_out[i] = 0;
                end else if (t) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_out[i] - imin(MAX_STEP, m_out[i]);
                end
            end
        endcase
        if (v)
            for (int i = 0; i < 4; i++) m_tgt[i] = int'(d[31-8*i -: 8]);
    endfunction

    function automatic logic [31:0] m_motor();
        return {8'(m_out[0]), 8'(m_out[1]), 8'(m_out[2]), 8'(m_out[3])};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check(name, 64'({motor_out, state, armed, cmd_ack}),
              64'({m_motor(), 2'(m_state), m_state == S_ARMED, m_ack}));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs settled.
    task automatic step(input logic v, input logic [31:0] d, input logic t,
                        input logic a, input logic k);
        cmd_valid  = v;
        cmd_data   = d;
        frame_tick = t;
        arm_req    = a;
        kill       = k;
        @(posedge clk);
        model_update(v, d, t, a, k);
        @(negedge clk);
    endtask

    task automatic tick();
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    // Expects zero targets and arm_req high; leaves the block ARMED.
    task automatic arm_sequence(input string tag);
        idle();
        for (int i = 1; i <= ARM_FRAMES; i++) begin
            tick();
            if (i == ARM_FRAMES - 1)
                check({tag, "_arming_at_99"}, 64'(state), 64'h1);
            if (i == ARM_FRAMES)
                check({tag, "_armed_at_100"}, 64'({state, armed}), 64'h5);
            idle();
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        t;
        logic        a;
        logic        k;
        logic [31:0] em;
        logic [1:0]  es;
        logic        eack;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic        rv, rt, ra, rk;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0};
        vecs[12] = '{1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1};
        vecs[13] = '{1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1};

        model_reset();
        #15;
        check("reset_state", 64'({motor_out, state, armed, cmd_ack}), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Arming acceptance, rejection and ack behaviour from DISARMED.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].t, vecs[i].a, vecs[i].k);
            check($sformatf("vec%0d", i), 64'({motor_out, state, cmd_ack}),
                  64'({vecs[i].em, vecs[i].es, vecs[i].eack}));
        end
        check_model("table_model_sync");

        arm_sequence("arm1");

        // Slew up toward 0x0A_FF_00_03, then back down to zero.
        step(1'b1, 32'h0AFF_0003, 1'b0, 1'b1, 1'b0);
        check("slew_cmd_ack", 64'(cmd_ack), 64'h1);
        tick();
        check("slew_up_t1", 64'(motor_out), 64'h0404_0003);
        idle();
        check("slew_hold", 64'(motor_out), 64'h0404_0003);
        tick();
        check("slew_up_t2", 64'(motor_out), 64'h0808_0003);
        tick();
        check("slew_up_t3", 64'(motor_out), 64'h0A0C_0003);
        step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check("slew_dn_t1", 64'(motor_out), 64'h0608_0000);
        tick();
        check("slew_dn_t2", 64'(motor_out), 64'h0204_0000);
        tick();
        check("slew_dn_t3", 64'(motor_out), 64'h0000_0000);
        check_model("slew_model_sync");

        // Watchdog expiry at 0x20202020 and the failsafe ramp.
        step(1'b1, 32'h2020_2020, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) tick();
        check("wd_tick9_armed", 64'({motor_out, state}), 64'({32'h2020_2020, 2'b10}));
        tick();
        check("wd_tick10_failsafe", 64'({motor_out, state, armed}), 64'({32'h2020_2020, 3'b110}));
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ramp_k%0d", k), 64'({motor_out, state}),
                  64'({{4{8'(32 - 4 * k)}}, 2'b11}));
        end
        step(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        check("failsafe_no_recover", 64'({motor_out, state}), 64'({32'h0, 2'b11}));
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("failsafe_disarm", 64'(state), 64'h0);

        // Command on the 10th tick keeps the block ARMED.
        arm_sequence("arm2");
        step(1'b1, 32'h2020_2020, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) tick();
        step(1'b1, 32'h2020_2020, 1'b1, 1'b1, 1'b0);
        check("wd_collision_armed", 64'({state, armed}), 64'h5);
        tick();
        check("wd_collision_still_armed", 64'(state), 64'h2);

        // Ramp to 0x80808080 with a command on every tick, then kill.
        for (int i = 0; i < 25; i++) step(1'b1, 32'h8080_8080, 1'b1, 1'b1, 1'b0);
        check("kill_pre_out", 64'({motor_out, state}), 64'({32'h8080_8080, 2'b10}));
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("kill_disarm", 64'({motor_out, state, armed}), 64'h0);
        step(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("kill_held", 64'(state), 64'h0);
        idle();
        check("kill_release_arming", 64'(state), 64'h1);
        check_model("kill_model_sync");

        // Colliding command and tick, followed by a back-to-back command.
        arm_sequence("arm3");
        step(1'b1, 32'h4040_4040, 1'b1, 1'b1, 1'b0);
        check("coll_first", 64'({motor_out, cmd_ack}), 64'({32'h0, 1'b1}));
        step(1'b1, 32'h0808_0808, 1'b0, 1'b1, 1'b0);
        check("coll_second_ack", 64'(cmd_ack), 64'h1);
        idle();
        check("coll_ack_drop", 64'(cmd_ack), 64'h0);
        tick();
        check("coll_slew_t1", 64'(motor_out), 64'h0404_0404);
        tick();
        check("coll_slew_t2", 64'(motor_out), 64'h0808_0808);

        // Asynchronous reset with nonzero outputs, between clock edges.
        #3 reset = 1'b0;
        #1 check("async_reset", 64'({motor_out, state, armed, cmd_ack}), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Randomized episodes compared against the model every cycle.
        for (int ep = 0; ep < 8; ep++) begin
            arm_sequence($sformatf("ep%0d", ep));
            for (int c = 0; c < 300; c++) begin
                rv = ($urandom_range(0, 2 + ep * 4) == 0);
                rd = $urandom;
                if ($urandom_range(0, 1) == 1) rd = rd & 32'h3F3F_3F3F;
                rt = ($urandom_range(0, 3) == 0);
                ra = ($urandom_range(0, 199) != 0);
                rk = ($urandom_range(0, 299) == 0);
                step(rv, rd, rt, ra, rk);
                check_model($sformatf("rand_ep%0d_c%0d", ep, c));
            end
            step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
            check_model($sformatf("rand_ep%0d_end", ep));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
